// File: rtl/hilo_div_ctrl_if.sv
// Signal bundle between the control unit / iterative divider and the HI/LO sequencer.
// The master side drives requests and divider status; the slave side is hilo_div_ctrl.
interface hilo_div_ctrl_if #(
  parameter int WIDTH = 32
);
  // control-unit side
  logic             div_req;
  logic             mthi_wr;
  logic             mtlo_wr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             div_zero_exc;
  logic             timeout_err;

  // divider side
  logic             div_start;
  logic             div_stop;
  logic             div_zero;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  modport master (
    output div_req, mthi_wr, mtlo_wr, wr_data,
    output div_stop, div_zero, div_hi, div_lo,
    input  div_start, hi, lo, busy, div_zero_exc, timeout_err
  );

  modport slave (
    input  div_req, mthi_wr, mtlo_wr, wr_data,
    input  div_stop, div_zero, div_hi, div_lo,
    output div_start, hi, lo, busy, div_zero_exc, timeout_err
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// DIV sequencer and HI/LO owner: fires a one-cycle divider start, waits for done, /0 or
// timeout, then captures the divider result into HI/LO. MTHI/MTLO are served while idle.
module hilo_div_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic           clk,
  input  logic           reset,
  hilo_div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             zero_exc_q;
  logic             timeout_q;

  logic             hi_wr_en;
  logic             lo_wr_en;
  logic             capture;
  logic             zero_hit;
  logic             timeout_hit;
  logic             wait_expired;

  assign wait_expired = (wait_cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each always_comb assigns defaults first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.div_req) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (bus.div_zero || bus.div_stop || wait_expired) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (state-only for busy/div_start; strobes for the datapath)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.busy      = 1'b0;
    bus.div_start = 1'b0;
    hi_wr_en      = 1'b0;
    lo_wr_en      = 1'b0;
    capture       = 1'b0;
    zero_hit      = 1'b0;
    timeout_hit   = 1'b0;
    unique case (state)
      IDLE: begin
        hi_wr_en = bus.mthi_wr;
        lo_wr_en = bus.mtlo_wr;
      end
      START: begin
        // divider flags may be stale from the previous op here, so they are not looked at
        bus.busy      = 1'b1;
        bus.div_start = 1'b1;
      end
      WAIT: begin
        bus.busy    = 1'b1;
        zero_hit    = bus.div_zero;
        capture     = !bus.div_zero && bus.div_stop;
        timeout_hit = !bus.div_zero && !bus.div_stop && wait_expired;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // WAIT-cycle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)              wait_cnt <= '0;
    else if (state == START) wait_cnt <= '0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Architectural HI/LO
  // ---------------------------------------------------------------------------
  // NOTE: HI/LO are architectural state that must read zero after reset, so they get a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (capture)       hi_q <= bus.div_hi;
      else if (hi_wr_en) hi_q <= bus.wr_data;
      if (capture)       lo_q <= bus.div_lo;
      else if (lo_wr_en) lo_q <= bus.wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags: /0 pulse follows the exit edge; timeout is sticky until reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_exc_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      zero_exc_q <= zero_hit;
      timeout_q  <= timeout_q | timeout_hit;
    end
  end

  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign bus.div_zero_exc = zero_exc_q;
  assign bus.timeout_err  = timeout_q;

  // ---------------------------------------------------------------------------
  // Embedded checks
  // ---------------------------------------------------------------------------
  a_start_one_cycle: assert property (@(posedge clk) disable iff (reset)
    bus.div_start |=> !bus.div_start);

  a_single_exit: assert property (@(posedge clk) disable iff (reset)
    $onehot0({zero_hit, capture, timeout_hit}));

  a_wait_bounded: assert property (@(posedge clk) disable iff (reset)
    (state == WAIT) |-> (wait_cnt <= CNT_LAST));

endmodule
